// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encoding, widths and sequencer state type
package alu_pkg;
  localparam int ALU_W = 64;
  localparam int ALU_CTL_W = 4;
  typedef enum logic [ALU_CTL_W-1:0] {
    ADD = 4'd1,
    SUB = 4'd2,
    MUL = 4'd3,
    SHL = 4'd4,
    SHR = 4'd5,
    DIV = 4'd6,
    NOT = 4'd7
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} alu_seq_state_e;
endpackage

// File: rtl/alu_seq.sv
// alu_seq: valid/ready sequencer in front of the registered ALU; issue, wait one cycle, capture, respond.
// Optional ALU_SEQ_DIVZERO_TRAP_EN answers DIV-by-zero locally with an error response instead of issuing it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CTL_W = ALU_CTL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CTL_W-1:0] req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CTL_W-1:0] alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);
  alu_seq_state_e state;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
      alu_ctl <= '0;
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
          if (req_op == CTL_W'(DIV) && req_b == '0) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_data <= '1;
            rsp_zero <= 1'b0;
            rsp_err <= 1'b1;
          end else
`endif
          begin
            alu_ctl <= req_op;
            alu_a <= req_a;
            alu_b <= req_b;
            state <= ISSUE;
          end
        end
        ISSUE: state <= CAPT;
        CAPT: begin
          rsp_data <= alu_out;
          rsp_zero <= alu_zero;
          rsp_err <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against a transaction-level model, with a behavioural ALU attached.
module tb_alu_seq;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, rsp_ready = 1;
  logic [3:0] req_op = 0;
  logic [63:0] req_a = 0, req_b = 0;
  logic req_ready, rsp_valid, rsp_zero, rsp_err, busy, alu_zero;
  logic [63:0] rsp_data, alu_a, alu_b, alu_out;
  logic [3:0] alu_ctl;
  int n_cmp = 0, n_bad = 0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  localparam bit TRAP = 1;
`else
  localparam bit TRAP = 0;
`endif

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_ref(logic [3:0] op, logic [63:0] a, logic [63:0] b);
    case (op)
      4'd2: return a - b;
      4'd3: return a * b;
      4'd4: return a << b[5:0];
      4'd5: return a >> b[5:0];
      4'd6: return (b == 0) ? '1 : a / b;
      4'd7: return ~a;
      default: return a + b;
    endcase
  endfunction

  // Behavioural ALU: registered result, unreset, zero flag from the register.
  always @(posedge clk) alu_out <= alu_ref(alu_ctl, alu_a, alu_b);
  assign alu_zero = alu_out == 0;

  // Transaction model: an accepted request answers after two edges (or at once when trapped) and holds until taken.
  bit m_busy, m_valid, m_zero, m_err, m_dchk, m_rchk;
  int m_age;
  logic [63:0] m_data, m_res, m_a, m_b;
  logic [3:0] m_ctl;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_age = 0; m_data = 0; m_zero = 0; m_err = 0;
      m_dchk = 1; m_ctl = 0; m_a = 0; m_b = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1;
        m_age = 0;
        if (TRAP && req_op == 6 && req_b == 0) begin
          m_valid = 1; m_data = '1; m_zero = 0; m_err = 1; m_dchk = 1;
        end else begin
          m_ctl = req_op; m_a = req_a; m_b = req_b;
          m_res = alu_ref(req_op, req_a, req_b);
          m_rchk = !(req_op == 6 && req_b == 0);
        end
      end
    end else if (m_valid) begin
      if (rsp_ready) begin m_valid = 0; m_busy = 0; end
    end else begin
      m_age++;
      if (m_age == 2) begin
        m_valid = 1; m_data = m_res; m_zero = m_res == 0; m_err = 0; m_dchk = m_rchk;
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 64'(req_ready), 64'(!m_busy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    chk("alu_ctl", 64'(alu_ctl), 64'(m_ctl));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (m_dchk) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit rr, done;
    done = 0;
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      rr = req_ready;
      step();
      done = rr;
    end
    req_valid = 0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got not-accepted expected accepted at %0t", $time);
    end
  endtask

  initial begin
    #12 rst_n = 1;
    step();
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    send(4'd1, 64'd5, 64'd7);
    chk("add_ctl", 64'(alu_ctl), 64'd1);
    chk("add_v1", 64'(rsp_valid), 64'd0);
    step();
    chk("add_v2", 64'(rsp_valid), 64'd0);
    step();
    chk("add_v3", 64'(rsp_valid), 64'd1);
    chk("add_data", rsp_data, 64'd12);
    chk("add_zero", 64'(rsp_zero), 64'd0);
    chk("add_err", 64'(rsp_err), 64'd0);
    step();
    send(4'd2, 64'd9, 64'd9);
    chk("sub_rdy1", 64'(req_ready), 64'd0);
    step();
    chk("sub_rdy2", 64'(req_ready), 64'd0);
    step();
    chk("sub_rdy3", 64'(req_ready), 64'd0);
    chk("sub_data", rsp_data, 64'd0);
    chk("sub_zero", 64'(rsp_zero), 64'd1);
    step();
    chk("sub_rdy4", 64'(req_ready), 64'd1);
    rsp_ready = 0;
    send(4'd3, 64'd3, 64'd4);
    req_valid = 1; req_op = 4'd1; req_a = 64'd1; req_b = 64'd1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", rsp_data, 64'd12);
      chk("bp_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 1;
    step();
    chk("bp_release", 64'(req_ready), 64'd1);
    chk("bp_nocapt", alu_a, 64'd3);
    step();
    req_valid = 0;
    chk("bp_accept", alu_a, 64'd1);
    step(); step(); step();
    chk("bp_next", rsp_data, 64'd2);
    step();
    send(4'd4, 64'd1, 64'd4);
    step();
    #2 rst_n = 0;
    #1;
    chk("mid_valid", 64'(rsp_valid), 64'd0);
    chk("mid_ctl", 64'(alu_ctl), 64'd0);
    chk("mid_a", alu_a, 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(req_ready), 64'd1);
    #2 rst_n = 1;
    step();
    send(4'd1, 64'd2, 64'd2);
    step(); step();
    chk("post_rst", rsp_data, 64'd4);
    step();
    send(4'd0, 64'd3, 64'd4);
    chk("op0_ctl", 64'(alu_ctl), 64'd0);
    step(); step();
    chk("op0_data", rsp_data, 64'd7);
    step();
    send(4'd6, 64'd10, 64'd0);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    chk("trap_ctl", 64'(alu_ctl), 64'd0);
    chk("trap_a", alu_a, 64'd3);
    chk("trap_valid", 64'(rsp_valid), 64'd1);
    chk("trap_data", rsp_data, '1);
    chk("trap_err", 64'(rsp_err), 64'd1);
    step();
    send(4'd6, 64'd10, 64'd2);
    step(); step();
    chk("div_data", rsp_data, 64'd5);
    chk("div_err", 64'(rsp_err), 64'd0);
    step();
`else
    chk("div0_ctl", 64'(alu_ctl), 64'd6);
    step(); step(); step();
`endif
    for (int i = 0; i < 3000; i++) begin
      req_valid = $urandom_range(0, 1) == 1;
      req_op = 4'($urandom);
      req_a = $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      req_b = $urandom_range(0, 5) == 0 ? 64'd0 : ($urandom_range(0, 1) == 1 ? 64'($urandom_range(0, 70)) : {$urandom, $urandom});
      if (req_op == 4'd2 && $urandom_range(0, 3) == 0) req_b = req_a;
      rsp_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
      step();
    end
    req_valid = 0;
    rsp_ready = 1;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
